// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the fetch port, the load/store port and
// the shared memory port. The arbiter uses the slave modport; the
// requesters and the memory model use the master modport.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    // instruction-fetch port
    logic              if_req_i;
    logic [AWIDTH-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DWIDTH-1:0] if_rdata_o;

    // load/store port
    logic              ls_req_i;
    logic              ls_we_i;
    logic [1:0]        ls_size_i;
    logic [AWIDTH-1:0] ls_addr_i;
    logic [DWIDTH-1:0] ls_wdata_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DWIDTH-1:0] ls_rdata_o;

    // memory port
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [DWIDTH-1:0] mem_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
        input  mem_data_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
        output mem_data_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressable memory (combinational read,
// posedge 4-byte write) between the fetch port and the load/store port.
// Requests are serialised through a small FSM; sub-word stores become a
// read-modify-write pair because the memory always writes a full word.
// Optional macro ARB_RR_EN: round-robin arbitration between the two ports
// instead of fixed load/store-over-fetch priority.
module mem_port_arbiter #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h01000000)
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t            state_q, state_d;
    logic              grant_if, grant_ls;

    // latched request (captured on the grant edge)
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              half_q;
    logic              owner_q;

    logic [DWIDTH-1:0] merge_q;
    logic [DWIDTH-1:0] if_rdata_q, ls_rdata_q;
    logic              if_rvalid_q, ls_rvalid_q;

`ifdef ARB_RR_EN
    logic              last_q;
`endif

    // Splice the stored byte (or half-word) into the word just read.
    function automatic logic [DWIDTH-1:0] merge_store(
        input logic [DWIDTH-1:0] old_word,
        input logic [DWIDTH-1:0] wdata,
        input logic              half
    );
        logic [DWIDTH-1:0] w;
        w       = old_word;
        w[7:0]  = wdata[7:0];
        if (half) begin
            w[15:8] = wdata[15:8];
        end
        return w;
    endfunction

    // Arbitration and next-state decode; grants only leave IDLE.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        state_d  = state_q;
        case (state_q)
            S_IDLE: begin
`ifdef ARB_RR_EN
                if (bus.ls_req_i && bus.if_req_i) begin
                    grant_ls = (last_q == OWN_IF);
                    grant_if = (last_q == OWN_LS);
                end else begin
                    grant_ls = bus.ls_req_i;
                    grant_if = bus.if_req_i;
                end
`else
                grant_ls = bus.ls_req_i;
                grant_if = bus.if_req_i && !bus.ls_req_i;
`endif
                if (grant_ls) begin
                    if (!bus.ls_we_i) begin
                        state_d = S_RD;
                    end else if (bus.ls_size_i[1]) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else if (grant_if) begin
                    state_d = S_RD;
                end
            end
            S_RD:     state_d = S_IDLE;
            S_WR:     state_d = S_IDLE;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs depend only on the state and the latched request.
    always_comb begin
        bus.mem_addr_o     = BASE_ADDR;
        bus.mem_data_o     = '0;
        bus.mem_read_en_o  = 1'b0;
        bus.mem_write_en_o = 1'b0;
        case (state_q)
            S_RD, S_RMW_RD: begin
                bus.mem_addr_o    = addr_q;
                bus.mem_read_en_o = 1'b1;
            end
            S_WR: begin
                bus.mem_addr_o     = addr_q;
                bus.mem_data_o     = wdata_q;
                bus.mem_write_en_o = 1'b1;
            end
            S_RMW_WR: begin
                bus.mem_addr_o     = addr_q;
                bus.mem_data_o     = merge_q;
                bus.mem_write_en_o = 1'b1;
            end
            default: ;
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request's fields and its owner.
    always_ff @(posedge clk) begin
        if (grant_ls) begin
            addr_q  <= bus.ls_addr_i;
            wdata_q <= bus.ls_wdata_i;
            half_q  <= (bus.ls_size_i == 2'b01);
            owner_q <= OWN_LS;
        end else if (grant_if) begin
            addr_q  <= bus.if_addr_i;
            wdata_q <= '0;
            half_q  <= 1'b0;
            owner_q <= OWN_IF;
        end
    end

    // Responses: registered read data, merge word and one-cycle valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            merge_q     <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            if_rvalid_q <= (state_q == S_RD) && (owner_q == OWN_IF);
            ls_rvalid_q <= ((state_q == S_RD) && (owner_q == OWN_LS)) ||
                           (state_q == S_WR) || (state_q == S_RMW_WR);
            if (state_q == S_RD) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= bus.mem_data_i;
                end else begin
                    ls_rdata_q <= bus.mem_data_i;
                end
            end
            if (state_q == S_RMW_RD) begin
                merge_q <= merge_store(bus.mem_data_i, wdata_q, half_q);
            end
        end
    end

`ifdef ARB_RR_EN
    // Remember which port won the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_IF;
        end else if (grant_ls) begin
            last_q <= OWN_LS;
        end else if (grant_if) begin
            last_q <= OWN_IF;
        end
    end
`endif

    assign bus.if_gnt_o    = grant_if;
    assign bus.ls_gnt_o    = grant_ls;
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.ls_rvalid_o = ls_rvalid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory model, directed scenarios,
// then random single-port transactions checked against a byte-level model.
module tb_mem_port_arbiter;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h01000000;
    localparam bit          P_IF = 1'b0;
    localparam bit          P_LS = 1'b1;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic preload;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int ls_rv_pulses = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         tb_last;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // memory: 256-byte window, combinational read, posedge 4-byte write
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (bus.mem_write_en_o) begin
            for (int k = 0; k < 4; k++)
                mem[8'(bus.mem_addr_o[7:0] + 8'(k))] <= bus.mem_data_o[8*k +: 8];
        end
    end

    always_comb begin
        bus.mem_data_i = '0;
        for (int k = 0; k < 4; k++)
            bus.mem_data_i[8*k +: 8] = mem[8'(bus.mem_addr_o[7:0] + 8'(k))];
    end

    always @(posedge clk) begin
        if (bus.mem_write_en_o) wr_pulses <= wr_pulses + 1;
        if (bus.ls_rvalid_o) ls_rv_pulses <= ls_rv_pulses + 1;
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(a[7:0] + 8'(k))];
        return w;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[8'(a[7:0] + 8'(k))] = wd[8*k +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on one port: request, wait for grant, wait for response.
    task automatic xact(input bit port, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int wait_c,
                        output int lat, output logic rden1);
        @(negedge clk);
        if (port == P_LS) begin
            bus.ls_req_i = 1'b1; bus.ls_we_i = we; bus.ls_size_i = size;
            bus.ls_addr_i = addr; bus.ls_wdata_i = wd;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        end
        wait_c = 0;
        #1;
        while (!((port == P_LS) ? bus.ls_gnt_o : bus.if_gnt_o) && wait_c < 20) begin
            @(negedge clk); #1;
            wait_c++;
        end
        tb_last = port;
        @(posedge clk); #1;
        bus.ls_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        lat = 1;
        @(negedge clk);
        rden1 = bus.mem_read_en_o;
        while (!((port == P_LS) ? bus.ls_rvalid_o : bus.if_rvalid_o) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = (port == P_LS) ? bus.ls_rdata_o : bus.if_rdata_o;
        if (port == P_LS && we) ref_store(size, addr, wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_gnt"},    32'(bus.if_gnt_o), 0);
        check({tag, "_ls_gnt"},    32'(bus.ls_gnt_o), 0);
        check({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 0);
        check({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid_o), 0);
        check({tag, "_if_rdata"},  bus.if_rdata_o, 0);
        check({tag, "_ls_rdata"},  bus.ls_rdata_o, 0);
        check({tag, "_mem_addr"},  bus.mem_addr_o, BASE);
        check({tag, "_mem_data"},  bus.mem_data_o, 0);
        check({tag, "_rd_en"},     32'(bus.mem_read_en_o), 0);
        check({tag, "_wr_en"},     32'(bus.mem_write_en_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, held, a, wd;
        int          wc, lat, w0, r0, exp_lat;
        logic        r1;
        bit          port, we, exp_last;
        logic [1:0]  size;
        int          busy;
        logic        exp_l, exp_i;

        bus.if_req_i = 0; bus.if_addr_i = '0;
        bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_size_i = 0;
        bus.ls_addr_i = '0; bus.ls_wdata_i = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        tb_last = P_IF;
        rst = 1'b1;
        preload = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        preload = 1'b0;
        rst = 1'b0;

        // fetch of a freshly stored word
        xact(P_LS, 1, 2'b10, BASE + 32'h10, 32'hDEADBEEF, rd, wc, lat, r1);
        check("st_word_lat", lat, 2);
        xact(P_IF, 0, 2'b10, BASE + 32'h10, 0, rd, wc, lat, r1);
        check("fetch_gnt_wait", wc, 0);
        check("fetch_rden_c1", 32'(r1), 1);
        check("fetch_lat", lat, 2);
        check("fetch_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        check("fetch_rvalid_pulse", 32'(bus.if_rvalid_o), 0);

        // word store then load
        xact(P_LS, 1, 2'b10, BASE + 32'h20, 32'h12345678, rd, wc, lat, r1);
        check("st_word2_lat", lat, 2);
        xact(P_LS, 0, 2'b10, BASE + 32'h20, 0, rd, wc, lat, r1);
        check("ld_word_data", rd, 32'h12345678);
        check("ld_word_lat", lat, 2);

        // byte store read-modify-write
        xact(P_LS, 1, 2'b11, BASE + 32'h20, 32'h11223344, rd, wc, lat, r1);
        held = bus.ls_rdata_o;
        check("st_keeps_rdata", held, 32'h12345678);
        xact(P_LS, 1, 2'b00, BASE + 32'h21, 32'hFFFFFFAB, rd, wc, lat, r1);
        check("st_byte_lat", lat, 3);
        xact(P_LS, 0, 2'b10, BASE + 32'h20, 0, rd, wc, lat, r1);
        check("ld_after_byte", rd, 32'h1122AB44);
        xact(P_LS, 0, 2'b10, BASE + 32'h21, 0, rd, wc, lat, r1);
        check("ld_unaligned_21", rd, ref_word(BASE + 32'h21));

        // half store read-modify-write
        xact(P_LS, 1, 2'b10, BASE + 32'h30, 32'hFFFFFFFF, rd, wc, lat, r1);
        xact(P_LS, 1, 2'b01, BASE + 32'h30, 32'h5555CAFE, rd, wc, lat, r1);
        check("st_half_lat", lat, 3);
        xact(P_LS, 0, 2'b10, BASE + 32'h30, 0, rd, wc, lat, r1);
        check("ld_after_half", rd, 32'hFFFFCAFE);

        // contention: both ports hold a load request for 6 cycles
        xact(P_IF, 0, 2'b10, BASE + 32'h44, 0, rd, wc, lat, r1);
        @(negedge clk);
        bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_size_i = 2'b10; bus.ls_addr_i = BASE + 32'h40;
        bus.if_req_i = 1; bus.if_addr_i = BASE + 32'h44;
        exp_last = tb_last;
        busy = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_l = 0; exp_i = 0;
            if (busy == 0) begin
                if (RR && exp_last == P_LS) begin exp_i = 1; exp_last = P_IF; end
                else begin exp_l = 1; exp_last = P_LS; end
                busy = 1;
            end else begin
                busy--;
            end
            check($sformatf("arb_ls_gnt_c%0d", c), 32'(bus.ls_gnt_o), 32'(exp_l));
            check($sformatf("arb_if_gnt_c%0d", c), 32'(bus.if_gnt_o), 32'(exp_i));
            if (c < 5) @(negedge clk);
        end
        bus.ls_req_i = 0;
        bus.if_req_i = 0;
        tb_last = exp_last;
        repeat (3) @(negedge clk);

        // random single-port traffic against the byte model
        for (int n = 0; n < 40; n++) begin
            port = 1'($urandom_range(0, 1));
            we   = (port == P_LS) ? 1'($urandom_range(0, 1)) : 1'b0;
            size = 2'($urandom_range(0, 3));
            a    = BASE + 32'($urandom_range(0, 255));
            wd   = $urandom;
            exp_lat = (we && !size[1]) ? 3 : 2;
            xact(port, we, size, a, wd, rd, wc, lat, r1);
            check($sformatf("rnd%0d_wait", n), wc, 0);
            check($sformatf("rnd%0d_lat", n), lat, exp_lat);
            if (!we) check($sformatf("rnd%0d_data", n), rd, ref_word(a));
        end

        // reset during the read phase of a byte store
        @(negedge clk);
        bus.ls_req_i = 1; bus.ls_we_i = 1; bus.ls_size_i = 2'b00;
        bus.ls_addr_i = BASE + 32'h50; bus.ls_wdata_i = 32'h000000EE;
        #1 check("rst_mid_gnt", 32'(bus.ls_gnt_o), 1);
        @(posedge clk); #1;
        bus.ls_req_i = 0;
        check("rst_mid_in_rmw_rd", 32'(bus.mem_read_en_o), 1);
        w0 = wr_pulses;
        r0 = ls_rv_pulses;
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tb_last = P_IF;
        repeat (3) @(negedge clk);
        check("rst_mid_no_write", wr_pulses, w0);
        check("rst_mid_no_rvalid", ls_rv_pulses, r0);
        xact(P_LS, 0, 2'b10, BASE + 32'h50, 0, rd, wc, lat, r1);
        check("rst_mid_mem_intact", rd, ref_word(BASE + 32'h50));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
